// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port, fixed-latency data SRAM between the instruction
// fetch requester (IF) and the load/store requester (MEM). One request is
// latched at a time and sequenced through IDLE -> ACCESS -> DONE. A wait-state
// counter holds ACCESS for WAIT_CYCLES cycles. Read data is captured in the
// last ACCESS cycle, and a one-cycle ready pulse is raised in DONE.
//
// Handshake: a requester raises *_req (level) with its address, and the
// write data/enable for MEM. It keeps them stable until its *_ready pulse.
// *_rdata is valid while *_ready=1 and holds until that requester's next
// completion. Requests are sampled only in IDLE. A request still held in the
// cycle after *_ready counts as a new request.
//
// Configuration macro:
//   MEM_ARB_RR_EN  defined   : when both requests are pending, grants
//                              alternate using a last-grant register.
//                              After reset the register holds MEM, so IF
//                              wins the first conflict.
//                  undefined : fixed priority, MEM over IF.
//
// Parameters:
//   SRAM_AW      SRAM word-address width (word addr = byte addr[SRAM_AW+1:2])
//   WAIT_CYCLES  SRAM access cycles per transfer, 1..15
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   if_req/if_addr         IF read request and byte address
//   if_rdata/if_ready      IF read data and completion pulse
//   if_stall               if_req & ~if_ready (combinational)
//   mem_req/mem_we         MEM request and write select
//   mem_addr/mem_wdata     MEM byte address and write data
//   mem_rdata/mem_ready    MEM read data and completion pulse
//   mem_stall              mem_req & ~mem_ready (combinational)
//   sram_addr/sram_wdata   SRAM word address and write data
//   sram_en/sram_we        SRAM enable and write enable
//   sram_rdata             SRAM read data, valid in the last access cycle
//   busy                   1 whenever the FSM is not in IDLE
//   state_dbg              current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int SRAM_AW     = 16,
    parameter int WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic [31:0]        if_rdata,
    output logic               if_ready,
    output logic               if_stall,
    input  logic               mem_req,
    input  logic               mem_we,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        mem_rdata,
    output logic               mem_ready,
    output logic               mem_stall,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [31:0]        sram_wdata,
    output logic               sram_en,
    output logic               sram_we,
    input  logic [31:0]        sram_rdata,
    output logic               busy,
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               gnt_mem_q, gnt_mem_d;   // 1: current transfer belongs to MEM
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]        sram_wdata_q, sram_wdata_d;
    logic               sram_en_q, sram_en_d;
    logic               sram_we_q, sram_we_d;
    logic [31:0]        if_rdata_q, if_rdata_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;
    logic               if_ready_q, if_ready_d;
    logic               mem_ready_q, mem_ready_d;
    logic               busy_q, busy_d;
    logic               grant_mem;

`ifdef MEM_ARB_RR_EN
    logic               last_mem_q, last_mem_d;  // 1: last grant went to MEM
`endif

    // Byte-offset bits and address bits above the SRAM range are not used.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:SRAM_AW+2], if_addr[1:0],
                                mem_addr[31:SRAM_AW+2], mem_addr[1:0]};

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            gnt_mem_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'd0;
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            if_rdata_q   <= 32'd0;
            mem_rdata_q  <= 32'd0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_mem_q    <= gnt_mem_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            busy_q       <= busy_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_mem_q <= 1'b1;
        end else begin
            last_mem_q <= last_mem_d;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Arbitration, used only when a grant is made in IDLE
    // -------------------------------------------------------------------------
    always_comb begin
        grant_mem = 1'b0;
`ifdef MEM_ARB_RR_EN
        if (mem_req && if_req) begin
            grant_mem = ~last_mem_q;
        end else begin
            grant_mem = mem_req;
        end
`else
        grant_mem = mem_req;
`endif
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_mem_d    = gnt_mem_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_en_d    = 1'b0;
        sram_we_d    = 1'b0;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_ready_d   = 1'b0;
        mem_ready_d  = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_mem_d   = last_mem_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (if_req || mem_req) begin
                    gnt_mem_d    = grant_mem;
                    sram_addr_d  = grant_mem ? mem_addr[SRAM_AW+1:2]
                                             : if_addr[SRAM_AW+1:2];
                    sram_wdata_d = mem_wdata;
                    sram_en_d    = 1'b1;
                    sram_we_d    = grant_mem & mem_we;  // IF is always a read
                    cnt_d        = CNT_LOAD;
                    state_d      = ST_ACCESS;
`ifdef MEM_ARB_RR_EN
                    last_mem_d   = grant_mem;
`endif
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last access cycle: SRAM read data is valid now.
                    if (!sram_we_q) begin
                        if (gnt_mem_q) begin
                            mem_rdata_d = sram_rdata;
                        end else begin
                            if_rdata_d  = sram_rdata;
                        end
                    end
                    if_ready_d  = ~gnt_mem_q;
                    mem_ready_d = gnt_mem_q;
                    state_d     = ST_DONE;
                end else begin
                    sram_en_d = 1'b1;
                    sram_we_d = sram_we_q;
                    cnt_d     = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign if_rdata   = if_rdata_q;
    assign if_ready   = if_ready_q;
    assign mem_rdata  = mem_rdata_q;
    assign mem_ready  = mem_ready_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_en    = sram_en_q;
    assign sram_we    = sram_we_q;
    assign busy       = busy_q;
    assign state_dbg  = state_q;

    assign if_stall  = if_req & ~if_ready_q;
    assign mem_stall = mem_req & ~mem_ready_q;

endmodule
